gate_eval_arbiter: RTL and testbench

Round-robin arbiter that shares one bitwise logic-gate evaluation unit among NUM_REQ requesters. Each requester presents operands A, B and a gate opcode with a valid/ready handshake. The winner's operation is evaluated and held in a single registered response stage, tagged with the requester index. It sits between the gate-level datapath (OR/AND/XOR family) and the blocks that need gate results, so one gate unit serves all clients.

---
 rtl/gate_pkg.sv | 15 +
 rtl/gate_unit.sv | 28 ++
 rtl/gate_eval_arbiter.sv | 106 ++++++++++
 tb/tb_gate_eval_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared opcode encodings for the bitwise gate datapath
package gate_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] GATE_AND  = 3'd0;
   localparam logic [OP_W-1:0] GATE_OR   = 3'd1;
   localparam logic [OP_W-1:0] GATE_NAND = 3'd2;
   localparam logic [OP_W-1:0] GATE_NOR  = 3'd3;
   localparam logic [OP_W-1:0] GATE_XOR  = 3'd4;
   localparam logic [OP_W-1:0] GATE_XNOR = 3'd5;
   localparam logic [OP_W-1:0] GATE_NOT  = 3'd6;
   localparam logic [OP_W-1:0] GATE_BUF  = 3'd7;

endpackage

// File: rtl/gate_unit.sv
// rtl/gate_unit.sv - combinational bitwise gate evaluator, reused by gate-level blocks
module gate_unit
   import gate_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         GATE_AND:  y = a & b;
         GATE_OR:   y = a | b;
         GATE_NAND: y = ~(a & b);
         GATE_NOR:  y = ~(a | b);
         GATE_XOR:  y = a ^ b;
         GATE_XNOR: y = ~(a ^ b);
         GATE_NOT:  y = ~a;
         GATE_BUF:  y = a;
         default:   y = '0;
      endcase
   end

endmodule

// File: rtl/gate_eval_arbiter.sv
// rtl/gate_eval_arbiter.sv - round-robin sharing of one gate_unit among NUM_REQ requesters
module gate_eval_arbiter
   import gate_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 1,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ*OP_W-1:0]  req_op,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_data,
   output logic [ID_W-1:0]          rsp_id
);

   logic [ID_W-1:0]    last_q, last_d;
   logic               valid_q, valid_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [ID_W-1:0]    id_q, id_d;

   logic [ID_W-1:0]    shift;
   logic [NUM_REQ-1:0] rot, rot_sel, grant;
   logic [ID_W-1:0]    gidx;
   logic [WIDTH-1:0]   a_sel, b_sel, gate_y;
   logic [OP_W-1:0]    op_sel;
   logic               slot_free, xfer;

   // Rotate so the index after last grant sits at bit 0, keep the lowest set bit, rotate back.
   always_comb begin
      shift   = (last_q == ID_W'(NUM_REQ - 1)) ? '0 : last_q + 1'b1;
      rot     = NUM_REQ'({req_valid, req_valid} >> shift);
      rot_sel = rot & (~rot + 1'b1);
      grant   = NUM_REQ'(({rot_sel, rot_sel} << shift) >> NUM_REQ);
   end

   always_comb begin
      gidx   = '0;
      a_sel  = '0;
      b_sel  = '0;
      op_sel = GATE_AND;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            gidx   = ID_W'(i);
            a_sel  = req_a[i*WIDTH +: WIDTH];
            b_sel  = req_b[i*WIDTH +: WIDTH];
            op_sel = req_op[i*OP_W +: OP_W];
         end
      end
   end

   gate_unit #(
      .WIDTH (WIDTH)
   ) u_gate (
      .a  (a_sel),
      .b  (b_sel),
      .op (op_sel),
      .y  (gate_y)
   );

   always_comb begin
      slot_free = !valid_q || rsp_ready;
      req_ready = (rst || !slot_free) ? '0 : grant;
      xfer      = |(req_valid & req_ready);
   end

   // A drain and a new transfer in the same cycle overwrite the slot with no bubble.
   always_comb begin
      last_d  = last_q;
      valid_d = valid_q;
      data_d  = data_q;
      id_d    = id_q;
      if (xfer) begin
         data_d  = gate_y;
         id_d    = gidx;
         valid_d = 1'b1;
         last_d  = gidx;
      end else if (rsp_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q  <= ID_W'(NUM_REQ - 1);
         valid_q <= 1'b0;
         data_q  <= '0;
         id_q    <= '0;
      end else begin
         last_q  <= last_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         id_q    <= id_d;
      end
   end

   assign rsp_valid = valid_q;
   assign rsp_data  = data_q;
   assign rsp_id    = id_q;

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// tb/tb_gate_eval_arbiter.sv - scoreboard bench for gate_eval_arbiter (NUM_REQ=4, WIDTH=4)
module tb_gate_eval_arbiter;
   import gate_pkg::*;

   localparam int N = 4;
   localparam int W = 4;

   typedef struct packed {
      logic [1:0]   id;
      logic [W-1:0] data;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a, req_b;
   logic [N*3-1:0] req_op;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [W-1:0]   rsp_data;
   logic [1:0]     rsp_id;

   logic [W-1:0]   a_arr [N];
   logic [W-1:0]   b_arr [N];
   logic [2:0]     op_arr [N];
   logic [W-1:0]   t3 [8];

   exp_t sb [$];
   int   n_chk  = 0;
   int   n_pass = 0;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_a[g*W +: W]  = a_arr[g];
      assign req_b[g*W +: W]  = b_arr[g];
      assign req_op[g*3 +: 3] = op_arr[g];
   end

   gate_eval_arbiter #(
      .NUM_REQ (N),
      .WIDTH   (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_ready(logic [N-1:0] e, string nm);
      #1;
      chk(nm, int'(req_ready), int'(e));
   endtask

   task automatic push(int id, logic [W-1:0] d);
      exp_t e;
      e.id   = 2'(id);
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic set_xor_all();
      for (int i = 0; i < N; i++) begin
         a_arr[i]  = W'(i);
         b_arr[i]  = 4'hF;
         op_arr[i] = GATE_XOR;
      end
   endtask

   always @(negedge clk) begin
      if (!rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL rsp_unexpected: got id %0d data %0h expected no response", rsp_id, rsp_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_id", int'(rsp_id), int'(e.id));
            chk("rsp_data", int'(rsp_data), int'(e.data));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      t3 = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1100};
      rst       = 1'b1;
      req_valid = '1;
      rsp_ready = 1'b1;
      set_xor_all();

      tick();
      exp_ready(4'b0000, "ready_in_reset");
      tick();
      chk("reset_rsp_valid", int'(rsp_valid), 0);
      chk("reset_rsp_data", int'(rsp_data), 0);
      chk("reset_rsp_id", int'(rsp_id), 0);
      rst       = 1'b0;
      req_valid = '0;

      // requester 2 alone, OR
      tick();
      req_valid = 4'b0100;
      a_arr[2]  = 4'b0001;
      b_arr[2]  = 4'b0000;
      op_arr[2] = GATE_OR;
      exp_ready(4'b0100, "t1_ready");
      push(2, 4'b0001);
      tick();
      req_valid = '0;
      chk("t1_rsp_valid", int'(rsp_valid), 1);
      tick();

      // all valid from reset: 0,1,2,3,0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_xor_all();
      for (int k = 0; k < 5; k++) begin
         tick();
         req_valid = '1;
         exp_ready(4'(1 << (k % 4)), "t2_rr_ready");
         push(k % 4, 4'hF ^ 4'(k % 4));
      end
      tick();
      req_valid = '0;
      tick();

      // opcode table on requester 1
      a_arr[1] = 4'b1100;
      b_arr[1] = 4'b1010;
      for (int op = 0; op < 8; op++) begin
         tick();
         req_valid = 4'b0010;
         op_arr[1] = 3'(op);
         exp_ready(4'b0010, "t3_op_ready");
         push(1, t3[op]);
      end
      tick();
      req_valid = '0;
      tick();

      // back-pressure with requesters 0 and 3
      tick();
      a_arr[0] = 4'hF;    b_arr[0] = 4'b0101; op_arr[0] = GATE_AND;
      a_arr[3] = 4'b0011; b_arr[3] = 4'b0101; op_arr[3] = GATE_OR;
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      exp_ready(4'b0001, "t4_first");
      push(0, 4'b0101);
      for (int s = 0; s < 3; s++) begin
         tick();
         rsp_ready = 1'b0;
         req_valid = 4'b1001;
         exp_ready(4'b0000, "t4_stall_ready");
         chk("t4_stall_valid", int'(rsp_valid), 1);
         chk("t4_stall_data", int'(rsp_data), 4'b0101);
         chk("t4_stall_id", int'(rsp_id), 0);
      end
      tick();
      rsp_ready = 1'b1;
      exp_ready(4'b1000, "t4_release");
      push(3, 4'b0111);
      tick();
      req_valid = 4'b0001;
      exp_ready(4'b0001, "t4_r0");
      push(0, 4'b0101);
      tick();
      req_valid = '0;
      tick();

      // reset while a response is pending
      set_xor_all();
      a_arr[1]  = 4'b1010;
      op_arr[1] = GATE_BUF;
      tick();
      req_valid = 4'b0010;
      exp_ready(4'b0010, "t5_pre");
      tick();
      req_valid = '1;
      rsp_ready = 1'b0;
      rst       = 1'b1;
      exp_ready(4'b0000, "t5_ready_rst");
      chk("t5_pending", int'(rsp_valid), 1);
      tick();
      rst = 1'b0;
      chk("t5_discard", int'(rsp_valid), 0);
      rsp_ready = 1'b1;
      set_xor_all();
      exp_ready(4'b0001, "t5_first");
      push(0, 4'hF);

      // withdrawal of granted requester 1 during stall
      tick();
      rsp_ready = 1'b0;
      req_valid = 4'b0110;
      exp_ready(4'b0000, "t6_stall_a");
      tick();
      req_valid = 4'b0100;
      exp_ready(4'b0000, "t6_stall_b");
      tick();
      rsp_ready = 1'b1;
      exp_ready(4'b0100, "t6_grant2");
      push(2, 4'hD);
      tick();
      req_valid = 4'b0111;
      exp_ready(4'b0001, "t6_wrap");
      push(0, 4'hF);
      tick();
      req_valid = '0;
      tick();
      tick();
      chk("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
